// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller signal bundle between pipeline and controller
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic             rs1_usedD;
  logic             rs2_usedD;
  logic [4:0]       rdE;
  logic             mem_readE;
  logic             br_takenE;
  logic             mem_reqM;
  logic             dmem_ready;
  logic             imem_ready;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1D, rs2D, rs1_usedD, rs2_usedD, rdE, mem_readE, br_takenE,
           mem_reqM, dmem_ready, imem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, rs1_usedD, rs2_usedD, rdE, mem_readE, br_takenE,
           mem_reqM, dmem_ready, imem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage RV32I pipeline
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

  state_t           state, state_nxt;
  logic [15:0]      wcnt, wcnt_nxt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             memstall, lu;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;

  assign memstall = hz.mem_reqM & ~hz.dmem_ready;
  assign lu = hz.mem_readE & (hz.rdE != 5'd0) &
              ((hz.rs1_usedD & (hz.rdE == hz.rs1D)) |
               (hz.rs2_usedD & (hz.rdE == hz.rs2D)));

  // Same-cycle stall/flush decode; memory wait outranks branch, load-use and fetch wait
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (memstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.br_takenE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (!hz.imem_ready) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  // Wait tracking: enter MEM_WAIT on a stalled access, leave on completion or dropped request
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (memstall) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 16'd1;
        end else begin
          wcnt_nxt = 16'd0;
        end
      end
      MEM_WAIT: begin
        if (memstall) begin
          wcnt_nxt = (wcnt == 16'hFFFF) ? wcnt : wcnt + 16'd1;
        end else begin
          state_nxt = RUN;
          wcnt_nxt  = 16'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = 16'd0;
      end
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= 16'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Sticky watchdog: trips on the wait cycle whose count reaches TIMEOUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_q <= 1'b0;
    end else if (memstall && (wcnt_nxt == TIMEOUT_V)) begin
      timeout_q <= 1'b1;
    end
  end

  // Saturating performance counters for fetch stalls and decode/execute bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_f && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_e && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   vec;
  int   errs;

  // reference model state: saturating counts, current wait-run length, sticky timeout
  int   m_stall;
  int   m_flush;
  int   m_run;
  logic m_to;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus.slave)
  );

  logic [6:0] ctrl;
  assign ctrl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                 bus.FlushD, bus.FlushE, bus.FlushW};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} from the priority rules
  function automatic logic [6:0] ref_ctrl();
    logic ms, hit1, hit2, luse;
    ms   = bus.mem_reqM && !bus.dmem_ready;
    hit1 = bus.rs1_usedD && (int'(bus.rdE) == int'(bus.rs1D));
    hit2 = bus.rs2_usedD && (int'(bus.rdE) == int'(bus.rs2D));
    luse = bus.mem_readE && (bus.rdE != 0) && (hit1 || hit2);
    if (!rst)                 return 7'b0000111;
    else if (ms)              return 7'b1111001;
    else if (bus.br_takenE)   return 7'b0000110;
    else if (luse)            return 7'b1100010;
    else if (!bus.imem_ready) return 7'b1000100;
    else                      return 7'b0000000;
  endfunction

  task automatic model_reset();
    m_stall = 0;
    m_flush = 0;
    m_run   = 0;
    m_to    = 1'b0;
  endtask

  task automatic drive(input logic r, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic mq,
                       input logic dr, input logic ir);
    rst            = r;
    bus.rs1D       = r1;
    bus.rs2D       = r2;
    bus.rs1_usedD  = u1;
    bus.rs2_usedD  = u2;
    bus.rdE        = rd;
    bus.mem_readE  = mr;
    bus.br_takenE  = br;
    bus.mem_reqM   = mq;
    bus.dmem_ready = dr;
    bus.imem_ready = ir;
    if (!r) model_reset();
    #1;
  endtask

  // one clock: advance the model with this cycle's expected controls, end on the falling edge
  task automatic tick();
    logic [6:0] e;
    e = ref_ctrl();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (e[6] && m_stall < CMAX) m_stall++;
      if (e[1] && m_flush < CMAX) m_flush++;
      if (bus.mem_reqM && !bus.dmem_ready) begin
        m_run++;
        if (m_run >= TIMEOUT) m_to = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      vec++;
      if (ctrl !== 7'b0000111) begin
        errs++;
        $display("FAIL reset_ctrl cyc=%0d got=%b want=0000111", i, ctrl);
      end
      tick();
      vec++;
      if (bus.stall_cnt !== 0 || bus.flush_cnt !== 0 || bus.mem_timeout !== 1'b0) begin
        errs++;
        $display("FAIL reset_regs got stall=%0d flush=%0d to=%b want 0 0 0",
                 bus.stall_cnt, bus.flush_cnt, bus.mem_timeout);
      end
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vec++;
    if (ctrl !== 7'b0000000) begin
      errs++;
      $display("FAIL reset_release got=%b want=0000000", ctrl);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 5, 0, 1, 5, 1, 0, 0, 0, 1);
    vec++;
    if (ctrl !== 7'b1100010) begin
      errs++;
      $display("FAIL lu_cycle1 got=%b want=1100010", ctrl);
    end
    tick();
    drive(1, 0, 5, 0, 1, 9, 0, 0, 1, 1, 1);
    vec++;
    if (ctrl !== 7'b0000000) begin
      errs++;
      $display("FAIL lu_cycle2 got=%b want=0000000", ctrl);
    end
    tick();
    vec++;
    if (bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd1) begin
      errs++;
      $display("FAIL lu_counts got stall=%0d flush=%0d want 1 1", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_no_hazard();
    drive(1, 0, 3, 1, 0, 0, 1, 0, 0, 0, 1);
    vec++;
    if (ctrl !== 7'b0000000) begin
      errs++;
      $display("FAIL lu_x0 got=%b want=0000000", ctrl);
    end
    tick();
    drive(1, 7, 3, 0, 1, 7, 1, 0, 0, 0, 1);
    vec++;
    if (ctrl !== 7'b0000000) begin
      errs++;
      $display("FAIL lu_unused got=%b want=0000000", ctrl);
    end
    tick();
  endtask

  task automatic test_branch_lu();
    drive(1, 4, 0, 1, 0, 4, 1, 1, 0, 0, 0);
    vec++;
    if (ctrl !== 7'b0000110) begin
      errs++;
      $display("FAIL br_lu got=%b want=0000110", ctrl);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, (i > 1), 1, 0, 1);
      vec++;
      if (ctrl !== 7'b1111001) begin
        errs++;
        $display("FAIL memwait cyc=%0d got=%b want=1111001", i, ctrl);
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    vec++;
    if (ctrl !== 7'b0000110) begin
      errs++;
      $display("FAIL memwait_done got=%b want=0000110", ctrl);
    end
    tick();
    vec++;
    if (bus.stall_cnt !== 4'd4 || bus.flush_cnt !== 4'd1 || bus.mem_timeout !== 1'b0) begin
      errs++;
      $display("FAIL memwait_regs got stall=%0d flush=%0d to=%b want 4 1 0",
               bus.stall_cnt, bus.flush_cnt, bus.mem_timeout);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      tick();
      vec++;
      if (bus.mem_timeout !== (i >= TIMEOUT)) begin
        errs++;
        $display("FAIL timeout wait=%0d got=%b want=%b", i, bus.mem_timeout, (i >= TIMEOUT));
      end
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    vec++;
    if (bus.mem_timeout !== 1'b1 || bus.stall_cnt !== 4'd15 || bus.flush_cnt !== 4'd0) begin
      errs++;
      $display("FAIL timeout_sticky_sat got to=%b stall=%0d flush=%0d want 1 15 0",
               bus.mem_timeout, bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) >= 2),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 80));
      e = ref_ctrl();
      vec++;
      if (ctrl !== e) begin
        errs++;
        $display("FAIL rand_ctrl i=%0d got=%b want=%b", i, ctrl, e);
      end
      tick();
      vec++;
      if (bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush) ||
          bus.mem_timeout !== m_to) begin
        errs++;
        $display("FAIL rand_regs i=%0d got stall=%0d flush=%0d to=%b want %0d %0d %b",
                 i, bus.stall_cnt, bus.flush_cnt, bus.mem_timeout, m_stall, m_flush, m_to);
      end
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline (F, D, E, M, W).
- Drives the stall and flush inputs of the four inter-stage registers.
- Covers load-use hazards, taken branches/jumps resolved in E, instruction-fetch wait and data-memory wait.
- A small FSM tracks multi-cycle data-memory stalls, with a timeout watchdog and saturating performance counters.

Parameters:
- TIMEOUT, 64: data-memory wait cycles before mem_timeout is raised; legal range 1 to 2^16-1.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1D  in  5  rs1 of the instruction in D.
- rs2D  in  5  rs2 of the instruction in D.
- rs1_usedD  in  1  instruction in D reads rs1.
- rs2_usedD  in  1  instruction in D reads rs2.
- rdE  in  5  destination register of the instruction in E.
- mem_readE  in  1  instruction in E is a load.
- br_takenE  in  1  branch taken or jump in E (redirects PC).
- mem_reqM  in  1  instruction in M is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold the F/D register.
- StallE  out  1  hold the D/E register.
- StallM  out  1  hold the E/M register.
- FlushD  out  1  load NOP (0x00000013) into the F/D register.
- FlushE  out  1  load NOP into the D/E register.
- FlushW  out  1  load a bubble into the M/W register.
- mem_timeout  out  1  sticky watchdog flag.
- stall_cnt  out  CNT_W  count of cycles with StallF=1.
- flush_cnt  out  CNT_W  count of cycles with FlushE=1.

Behaviour:
State and reset:
- States are RUN and MEM_WAIT, plus a wait counter wcnt (16 bit).
- rst=0 (asynchronous) forces: state=RUN, wcnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- While rst=0: all Stall* outputs are 0; FlushD=1, FlushE=1, FlushW=1.
- Reset asserted mid-wait abandons the wait with no further side effects.

Control outputs:
- Combinational (Mealy) from state and inputs, applied in the same cycle. Zero added latency.
- Definitions used below:
  - memstall = mem_reqM & ~dmem_ready.
  - lu = mem_readE & (rdE != 0) & ((rs1_usedD & rdE == rs1D) | (rs2_usedD & rdE == rs2D)).

Priority, highest first:
1. memstall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
   - A br_takenE or lu arriving in the same cycle is deferred. The stalled stages keep presenting those inputs, so they are handled once memstall clears.
2. br_takenE: FlushD=1, FlushE=1, all stalls 0.
   - Load-use is ignored because the instruction in D is being killed.
   - imem_ready is ignored.
3. lu: StallF=StallD=1, FlushE=1 for exactly one cycle.
   - Next cycle the load has moved to M, so lu drops naturally.
4. ~imem_ready: StallF=1, FlushD=1.
5. Otherwise all outputs are 0.

FSM:
- RUN -> MEM_WAIT when memstall; wcnt <= 1.
- MEM_WAIT stays while memstall; wcnt increments, saturating at 16'hFFFF.
  - When wcnt == TIMEOUT, set mem_timeout=1. It stays set until reset.
- MEM_WAIT -> RUN when dmem_ready=1; wcnt <= 0. Stalls drop in that same cycle.
- RUN with mem_reqM & dmem_ready (single-cycle access) stays in RUN with no stall.
- Back-to-back accesses: each new memstall re-enters MEM_WAIT. wcnt restarts at 1.
- mem_reqM dropping while in MEM_WAIT is a protocol error. Treat it as completion: return to RUN.

Counters:
- stall_cnt and flush_cnt each add 1 per qualifying cycle. Both saturate at all-ones and never wrap.

Test Plan:
1. Reset: rst=0 for 3 cycles with random inputs -> FlushD=FlushE=FlushW=1, stalls=0, counters=0. Release -> state RUN.
2. Load-use: mem_readE=1, rdE=5, rs2D=5, rs2_usedD=1 -> one cycle of StallF=StallD=FlushE=1. Next cycle (load in M, dmem_ready=1) all outputs 0. stall_cnt=1, flush_cnt=1.
3. rdE=0 with rs1D=0, mem_readE=1 -> no stall. Same with rdE=rs1D=7 and rs1_usedD=0 -> no stall.
4. Branch plus load-use together: br_takenE=1 and lu=1 -> FlushD=FlushE=1, StallF=0.
5. Memory wait: mem_reqM=1, dmem_ready=0 for 4 cycles, then 1 -> StallF..StallM=1 and FlushW=1 for 4 cycles, 0 on the 5th. Raising br_takenE during the wait -> no flush until cycle 5.
6. Timeout: TIMEOUT=8, dmem_ready held 0 for 10 cycles -> mem_timeout rises on wait cycle 8 and stays 1 after completion. With CNT_W=4, 20 stall cycles -> stall_cnt=15.
